// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Latency: none (types and constants only).
// Backpressure: none.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_full_sub.sv
// 1-bit full subtractor: d = a - b - bin, with borrow out.
// Latency: combinational.
// Backpressure: none.
module full_sub (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  // Borrow when a < b, or when a == b and a borrow is already pending.
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor Minuend - Subtrahend, LSB first, one bit per clock.
// Latency: Start edge -> WIDTH shift edges -> Done pulse in cycle WIDTH+1.
// Backpressure: Start is ignored while Busy; a new Start is taken in IDLE or in the Done cycle.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] MinuendDin,
  input  logic [WIDTH-1:0] SubtrahendDin,
  output logic             Busy,
  output logic             Done,
  output logic             DiffBit,
  output logic [WIDTH-1:0] DiffDout,
  output logic             BorrowOut,
  output logic             Overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] sub_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             borrow_out_q;
  logic             ovf_q;

  logic load;
  logic shift;
  logic last_bit;
  logic d_bit;
  logic bout;

  // Bit 0 of each operand register is the bit being processed this cycle.
  full_sub u_full_sub (
    .a_i    (min_q[0]),
    .b_i    (sub_q[0]),
    .bin_i  (br_q),
    .d_o    (d_bit),
    .bout_o (bout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and load/shift strobes; a Start in the Done cycle chains straight into a new op.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (Start) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand/result shifting and final flag capture.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      min_q        <= '0;
      sub_q        <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      br_q         <= 1'b0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (load) begin
      min_q        <= MinuendDin;
      sub_q        <= SubtrahendDin;
      cnt_q        <= '0;
      br_q         <= 1'b0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (shift) begin
      min_q  <= min_q >> 1;
      sub_q  <= sub_q >> 1;
      diff_q <= {d_bit, diff_q[WIDTH-1:1]};
      cnt_q  <= cnt_q + CNT_W'(1);
      br_q   <= bout;
      if (last_bit) begin
        // On the last edge bit 0 holds the original sign bits.
        borrow_out_q <= bout;
        ovf_q        <= (min_q[0] != sub_q[0]) && (d_bit != min_q[0]);
      end
    end
  end

  assign Busy      = (state_q == ST_SHIFT);
  assign Done      = (state_q == ST_DONE);
  assign DiffBit   = d_bit;
  assign DiffDout  = diff_q;
  assign BorrowOut = borrow_out_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=4 main instance, WIDTH=8 spot instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_sub;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Start;
  logic [3:0] MinuendDin, SubtrahendDin;
  logic       Busy, Done, DiffBit, BorrowOut, Overflow;
  logic [3:0] DiffDout;

  logic       Start8;
  logic [7:0] Min8, Sub8, Diff8;
  logic       Busy8, Done8, DiffBit8, Borrow8, Ovf8;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  serial_sub #(.WIDTH(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
    .MinuendDin(MinuendDin), .SubtrahendDin(SubtrahendDin),
    .Busy(Busy), .Done(Done), .DiffBit(DiffBit), .DiffDout(DiffDout),
    .BorrowOut(BorrowOut), .Overflow(Overflow)
  );

  serial_sub #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start8),
    .MinuendDin(Min8), .SubtrahendDin(Sub8),
    .Busy(Busy8), .Done(Done8), .DiffBit(DiffBit8), .DiffDout(Diff8),
    .BorrowOut(Borrow8), .Overflow(Ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 4-bit values.
  function automatic int ref_diff(input int m, input int s);
    return ((m - s) % 16 + 16) % 16;
  endfunction

  function automatic int ref_borrow(input int m, input int s);
    return (m < s) ? 1 : 0;
  endfunction

  function automatic int ref_ovf(input int m, input int s);
    int sm, ss, r;
    sm = (m >= 8) ? m - 16 : m;
    ss = (s >= 8) ? s - 16 : s;
    r  = sm - ss;
    return (r < -8 || r > 7) ? 1 : 0;
  endfunction

  // One isolated operation: pulse Start, collect the serial bits, check final outputs.
  task automatic do_op(input int m, input int s);
    int cyc, bits, idx;
    @(negedge Clk);
    Start = 1'b1; MinuendDin = 4'(m); SubtrahendDin = 4'(s);
    @(negedge Clk);
    Start = 1'b0;
    cyc = 1; bits = 0; idx = 0;
    while (!Done && cyc < 20) begin
      if (Busy && idx < 4) begin
        bits = bits | (int'(DiffBit) << idx);
        idx++;
      end
      @(negedge Clk);
      cyc++;
    end
    chk("latency", cyc, 5);
    chk("done", Done, 1);
    chk("diff", DiffDout, ref_diff(m, s));
    chk("serial_bits", bits, ref_diff(m, s));
    chk("borrow", BorrowOut, ref_borrow(m, s));
    chk("overflow", Overflow, ref_ovf(m, s));
    @(negedge Clk);
    chk("done_pulse", Done, 0);
  endtask

  initial begin
    int order[256];
    int cyc;
    int am, as, bm, bs;

    Rst_n = 1'b0; Start = 1'b0; MinuendDin = '0; SubtrahendDin = '0;
    Start8 = 1'b0; Min8 = '0; Sub8 = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_diff", DiffDout, 0);
    chk("rst_borrow", BorrowOut, 0);
    chk("rst_ovf", Overflow, 0);
    Rst_n = 1'b1;

    // Directed cases with literal expectations.
    do_op(9, 3);
    chk("9m3_diff", DiffDout, 4'b0110);
    chk("9m3_ovf", Overflow, 1);
    do_op(3, 5);
    chk("3m5_diff", DiffDout, 4'b1110);
    chk("3m5_borrow", BorrowOut, 1);
    do_op(8, 1);
    chk("8m1_diff", DiffDout, 4'b0111);
    chk("8m1_ovf", Overflow, 1);
    do_op(0, 0);
    chk("0m0_flags", {BorrowOut, Overflow}, 0);

    // Start held for 10 cycles; operands change mid-shift.
    am = $urandom_range(15); as = $urandom_range(15);
    bm = $urandom_range(15); bs = $urandom_range(15);
    @(negedge Clk);
    Start = 1'b1; MinuendDin = 4'(am); SubtrahendDin = 4'(as);
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c == 2) begin MinuendDin = 4'(bm); SubtrahendDin = 4'(bs); end
      if (c == 7) begin MinuendDin = 4'(am ^ 5); SubtrahendDin = 4'(as ^ 9); end
      chk("held_done", Done, (c == 5 || c == 10) ? 1 : 0);
      if (c == 5) begin
        chk("held1_diff", DiffDout, ref_diff(am, as));
        chk("held1_borrow", BorrowOut, ref_borrow(am, as));
        chk("held1_ovf", Overflow, ref_ovf(am, as));
      end
      if (c == 10) begin
        chk("held2_diff", DiffDout, ref_diff(bm, bs));
        chk("held2_borrow", BorrowOut, ref_borrow(bm, bs));
        chk("held2_ovf", Overflow, ref_ovf(bm, bs));
        Start = 1'b0;
      end
    end

    // Reset during the second shift cycle of 6-2.
    @(negedge Clk);
    Start = 1'b1; MinuendDin = 4'd6; SubtrahendDin = 4'd2;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_done", Done, 0);
    chk("mid_rst_diff", DiffDout, 0);
    chk("mid_rst_borrow", BorrowOut, 0);
    Rst_n = 1'b1;
    cyc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (Done) cyc++;
    end
    chk("no_done_after_rst", cyc, 0);
    do_op(6, 2);
    chk("6m2_diff", DiffDout, 4'b0100);

    // All 256 operand pairs in shuffled order.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 256; i++) do_op(order[i] >> 4, order[i] & 15);

    // WIDTH=8 spot check: 200 - 55.
    @(negedge Clk);
    Start8 = 1'b1; Min8 = 8'd200; Sub8 = 8'd55;
    @(negedge Clk);
    Start8 = 1'b0;
    cyc = 1;
    while (!Done8 && cyc < 30) begin
      @(negedge Clk);
      cyc++;
    end
    chk("w8_latency", cyc, 9);
    chk("w8_diff", Diff8, 145);
    chk("w8_borrow", Borrow8, 0);
    chk("w8_ovf", Ovf8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
